// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with standard or show-ahead read, threshold flags, flush and drop/refuse pulses.
// Optional high-water mark tracking is enabled by defining FIFO_SYNC_EXT_WATERMARK_EN.
module fifo_sync_ext #(
  parameter int DEPTH     = 32,
  parameter int DW        = 32,
  parameter int SHOWAHEAD = 0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic          req_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          afull_o,
  output logic          aempty_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  output logic          underflow_o
`ifdef FIFO_SYNC_EXT_WATERMARK_EN
  ,
  input  logic          wm_clr_i,
  output logic [CW-1:0] max_count_o
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full, empty, pop, wr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign pop   = req_i && !empty;
  assign wr    = valid_i && (!full || pop);

  always_comb begin
    count_nxt = count;
    if (wr && !pop)      count_nxt = count + CW'(1);
    else if (pop && !wr) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i || flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nxt;
      overflow_o  <= valid_i && !wr;
      underflow_o <= req_i && empty;
    end
  end

  // Storage is never reset; only pointers and count define what is live.
  always_ff @(posedge clk_i) begin
    if (!srst_i && !flush_i && wr) mem[wr_ptr] <= data_i;
  end

  assign count_o  = count;
  assign full_o   = full;
  assign empty_o  = empty;
  assign afull_o  = (count >= CW'(AFULL_TH));
  assign aempty_o = (count <= CW'(AEMPTY_TH));

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Head word is always on the output; forced to zero while nothing is stored.
      assign valid_o = !empty;
      assign data_o  = empty ? '0 : mem[rd_ptr];
    end else begin : g_standard
      logic          valid_q;
      logic [DW-1:0] data_q;
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (flush_i) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= pop;
          if (pop) data_q <= mem[rd_ptr];
        end
      end
      assign valid_o = valid_q;
      assign data_o  = data_q;
    end
  endgenerate

`ifdef FIFO_SYNC_EXT_WATERMARK_EN
  logic [CW-1:0] max_q, cnt_eff;
  logic          inc;
  assign cnt_eff = flush_i ? '0 : count_nxt;
  assign inc     = !flush_i && wr && !pop;

  always_ff @(posedge clk_i) begin
    if (srst_i)                max_q <= '0;
    else if (wm_clr_i)         max_q <= inc ? cnt_eff : '0;
    else if (cnt_eff > max_q)  max_q <= cnt_eff;
  end
  assign max_count_o = max_q;
`endif
endmodule

// File: tb/tb_fifo_sync_ext.sv
// Randomized scoreboard bench: a standard-read and a show-ahead instance share stimulus and a queue model.
module tb_fifo_sync_ext;
  localparam int DEPTH = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AFT   = DEPTH - 2;
  localparam int AET   = 1;

  logic clk = 0;
  logic srst = 1, flush = 0, valid = 0, req = 0, wm_clr = 0;
  logic [DW-1:0] din = '0;
  logic v0, v1, f0, f1, e0, e1, af0, af1, ae0, ae1, ov0, ov1, un0, un1;
  logic [DW-1:0] d0, d1;
  logic [CW-1:0] c0, c1;
`ifdef FIFO_SYNC_EXT_WATERMARK_EN
  logic [CW-1:0] mx0, mx1;
`endif

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mq[$];      // reference contents, head at index 0
  logic [DW-1:0] exp_q[$];   // expected standard-read outputs
  int wm = 0;

  always #5 clk = ~clk;

  fifo_sync_ext #(.DEPTH(DEPTH), .DW(DW), .SHOWAHEAD(0)) u_sa0 (
    .clk_i(clk), .srst_i(srst), .flush_i(flush), .valid_i(valid), .data_i(din), .req_i(req),
    .valid_o(v0), .data_o(d0), .full_o(f0), .empty_o(e0), .afull_o(af0), .aempty_o(ae0),
    .count_o(c0), .overflow_o(ov0), .underflow_o(un0)
`ifdef FIFO_SYNC_EXT_WATERMARK_EN
    , .wm_clr_i(wm_clr), .max_count_o(mx0)
`endif
  );

  fifo_sync_ext #(.DEPTH(DEPTH), .DW(DW), .SHOWAHEAD(1)) u_sa1 (
    .clk_i(clk), .srst_i(srst), .flush_i(flush), .valid_i(valid), .data_i(din), .req_i(req),
    .valid_o(v1), .data_o(d1), .full_o(f1), .empty_o(e1), .afull_o(af1), .aempty_o(ae1),
    .count_o(c1), .overflow_o(ov1), .underflow_o(un1)
`ifdef FIFO_SYNC_EXT_WATERMARK_EN
    , .wm_clr_i(wm_clr), .max_count_o(mx1)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every standard-read output word must match the next scoreboard entry.
  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sa0_unexpected_valid: got data %0h expected no output", d0);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (d0 !== e) begin
          n_fail++;
          $display("FAIL sa0_data: got %0h expected %0h at %0t", d0, e, $time);
        end
      end
    end
  end

  task automatic step(input bit s, input bit f, input bit v, input logic [DW-1:0] d,
                      input bit r, input bit c = 1'b0);
    int  sz;
    bit  pp, ov, un;
    sz = mq.size();
    srst = s; flush = f; valid = v; din = d; req = r; wm_clr = c;
    pp = r && (sz > 0);
    ov = v && (sz == DEPTH) && !pp;
    un = r && (sz == 0);
    if (s || f) begin
      mq.delete();
      pp = 0; ov = 0; un = 0;
    end else begin
      if (pp) exp_q.push_back(mq.pop_front());
      if (v && !ov) mq.push_back(d);
    end
    if (s)      wm = 0;
    else if (c) wm = (mq.size() > sz) ? mq.size() : 0;
    else if (mq.size() > wm) wm = mq.size();
    @(posedge clk); #1;
    sz = mq.size();
    chk("count",     c0,  sz);
    chk("count_sa1", c1,  sz);
    chk("full",      f0,  sz == DEPTH);
    chk("empty",     e0,  sz == 0);
    chk("afull",     af0, sz >= AFT);
    chk("aempty",    ae0, sz <= AET);
    chk("overflow",  ov0, ov);
    chk("underflow", un0, un);
    chk("ovf_sa1",   ov1, ov);
    chk("unf_sa1",   un1, un);
    chk("sa0_valid", v0,  pp);
    chk("sa1_valid", v1,  sz > 0);
    if (sz > 0) chk("sa1_head", d1, mq[0]);
    if (s) begin
      chk("rst_data_sa0", d0, 0);
      chk("rst_data_sa1", d1, 0);
    end
`ifdef FIFO_SYNC_EXT_WATERMARK_EN
    chk("max_count", mx0, wm);
`endif
    srst = 0; flush = 0; valid = 0; req = 0; wm_clr = 0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    // fill to 30, then to full, then two dropped writes
    for (int i = 0; i < 34; i++) step(0, 0, 1, i, 0);
    // drain with two refused pops at the end
    for (int i = 0; i < 34; i++) step(0, 0, 0, 0, 1);
    // pointer wrap: random traffic keeping occupancy in 1..32
    for (int i = 0; i < 16; i++) step(0, 0, 1, $urandom, 0);
    for (int i = 0; i < 200; i++) begin
      bit v, r;
      v = (mq.size() < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b1;
      r = (mq.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(0, 0, v, $urandom, r);
    end
    // full with simultaneous write and pop
    while (mq.size() < DEPTH) step(0, 0, 1, $urandom, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, $urandom, 1);
    // show-ahead: single word, visible without a request, then acknowledged
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 32'hA5, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    // flush with concurrent write/read, then watermark clear
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, $urandom, 0);
    step(0, 1, 1, $urandom, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h1234, 0, 1);
    // reset mid-operation
    for (int i = 0; i < 5; i++) step(0, 0, 1, $urandom, 0);
    step(1, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
